// File: rtl/rc6_io_pkg.sv
// Shared types and constants for the RC6 chip-level I/O front-end.
package rc6_io_pkg;

   localparam int BLK_W = 128;

   typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_STORE} state_t;

   function automatic int beats(input int bus_w);
      return BLK_W / bus_w;
   endfunction

endpackage

// File: rtl/rc6_blk_fifo.sv
// Block-wide synchronous FIFO; head is presented combinationally, count tracks occupancy.
module rc6_blk_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 2,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          zset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (zset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rc6_chip_io.sv
// Narrow pad bus to 128-bit RC6 core adapter: beat assembly, core handshake,
// result FIFO and beat-sliced output stream.
module rc6_chip_io #(
   parameter int BUS_W = 32,
   parameter int BLK_W = 128,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             zset,
   input  logic             inen,
   input  logic [BUS_W-1:0] data_in,
   input  logic             mode_in,
   output logic             in_ready,
   output logic             core_start,
   output logic [BLK_W-1:0] core_din,
   output logic             core_mode,
   input  logic             core_done,
   input  logic [BLK_W-1:0] core_dout,
   output logic             out_valid,
   input  logic             outen,
   output logic [BUS_W-1:0] data_out,
   output logic             fifo_full,
   output logic [CNT_W-1:0] blk_cnt
);

   import rc6_io_pkg::*;

   localparam int BEATS = beats(BUS_W);
   localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     in_idx, out_idx;
   logic [BLK_W-1:0]  res, head;
   logic [CW-1:0]     count;
   logic              push, fifo_empty, in_acc, out_acc, pop;

   assign in_acc  = inen && in_ready;
   assign out_acc = outen && out_valid;
   assign pop     = out_acc && (out_idx == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     state_q <= S_LOAD;
      else if (zset) state_q <= S_LOAD;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      core_start = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (inen && in_idx == LAST) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            core_start = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: if (core_done) state_d = S_STORE;
         S_STORE: begin
            // count is registered, so a pop this cycle frees the slot only next cycle
            if (count < CW'(DEPTH)) begin
               push    = 1'b1;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_idx    <= '0;
         out_idx   <= '0;
         core_din  <= '0;
         core_mode <= 1'b0;
         res       <= '0;
         blk_cnt   <= '0;
      end else if (zset) begin
         in_idx    <= '0;
         out_idx   <= '0;
         core_din  <= '0;
         core_mode <= 1'b0;
         res       <= '0;
         blk_cnt   <= '0;
      end else begin
         if (in_acc) begin
            core_din[in_idx*BUS_W +: BUS_W] <= data_in;
            if (in_idx == '0) core_mode <= mode_in;
            in_idx <= (in_idx == LAST) ? '0 : in_idx + IW'(1);
         end
         if (state_q == S_WAIT && core_done) res <= core_dout;
         if (push) blk_cnt <= blk_cnt + CNT_W'(1);
         if (out_acc) out_idx <= (out_idx == LAST) ? '0 : out_idx + IW'(1);
      end
   end

   rc6_blk_fifo #(.W(BLK_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .zset  (zset),
      .push  (push),
      .din   (res),
      .pop   (pop),
      .head  (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   // FIFO storage is not reset, so mask the head while empty
   assign data_out  = out_valid ? head[out_idx*BUS_W +: BUS_W] : '0;

endmodule

// File: doc/rc6_chip_io.md
Name: rc6_chip_io

Overview:
Parametrised chip-level I/O front-end for the RC6 datapath. It assembles 128-bit blocks from a narrow pad bus of BUS_W bits and issues each block to the cipher core with a start/done handshake. It buffers results in a DEPTH-block output FIFO and streams them back out BUS_W bits per beat. It sits between the pad ring and the RC6 core inside the chip top, so the 128-bit pad buses become BUS_W wide.

Parameters:
BUS_W, 32, pad data width; legal values 8/16/32/64/128; must divide BLK_W.
BLK_W, 128, cipher block width; fixed by RC6-32/20.
DEPTH, 2, output FIFO depth in blocks; minimum 1.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
zset  in  1  synchronous clear; same effect as reset, applied on the clock edge
inen  in  1  input beat valid
data_in  in  BUS_W  input beat
mode_in  in  1  0 = encrypt, 1 = decrypt; sampled with beat 0 of a block
in_ready  out  1  input beat accepted when inen && in_ready
core_start  out  1  one-cycle start pulse to the core
core_din  out  BLK_W  assembled block; stable from core_start until core_done
core_mode  out  1  latched mode for the current block
core_done  in  1  core result valid, one-cycle pulse
core_dout  in  BLK_W  core result
out_valid  out  1  output beat available
outen  in  1  output beat accepted when outen && out_valid
data_out  out  BUS_W  output beat
fifo_full  out  1  FIFO holds DEPTH blocks
blk_cnt  out  CNT_W  number of blocks written into the FIFO; wraps modulo 2^CNT_W

Behaviour:
- Derived constant: BEATS = BLK_W/BUS_W. Beat k occupies bits [k*BUS_W +: BUS_W], so the first beat is the least-significant slice. The same order applies on output.
- Reset or zset forces the following values:
  - state = S_LOAD, beat counters = 0, FIFO empty, blk_cnt = 0;
  - core_start = 0, in_ready = 1, out_valid = 0, fifo_full = 0;
  - data_out = 0, core_din = 0, core_mode = 0.
- zset has priority over every other event in the same cycle.
- Control FSM:
  - S_LOAD: in_ready = 1. Each accepted beat writes the slice at index in_idx, then in_idx increments. mode_in is latched on beat 0. On the accepted beat with in_idx = BEATS-1, in_idx returns to 0 and the FSM moves to S_ISSUE.
  - S_ISSUE: core_start = 1 for exactly this cycle, then S_WAIT. in_ready = 0.
  - S_WAIT: wait for core_done, then capture core_dout into a result register and move to S_STORE. core_done in any other state is ignored. The wait has no timeout.
  - S_STORE: if count < DEPTH, write the result into the FIFO, increment blk_cnt, then S_LOAD. Otherwise stay in S_STORE; this stall is the backpressure path.
- Latency:
  - Last input beat accepted at edge t gives core_start high in cycle t+1.
  - core_done high at edge u gives the FIFO write at u+1 and out_valid high in cycle u+2 when the FIFO was empty.
  - Minimum block-to-block input turnaround is BEATS + 3 cycles plus core latency.
- Output side:
  - out_valid = FIFO not empty. data_out = slice out_idx of the head block, driven combinationally from the FIFO head.
  - On each accepted output beat, out_idx increments. On beat BEATS-1, the head is popped and out_idx returns to 0.
  - A pop in the same cycle as a stalled S_STORE does not admit the push that cycle; the push occurs the next cycle. Writes never occur when count = DEPTH.
  - Pointers wrap modulo DEPTH. count is held in a separate counter of width clog2(DEPTH+1).
- Input and output sides run concurrently. With BUS_W = BLK_W, BEATS = 1 and the index counters are constant 0.
- Reset asserted mid-block discards any partial block, the in-flight core job and all FIFO contents. A core_done arriving after reset while in S_LOAD is ignored.

Decomposition:
- Package rc6_io_pkg holds:
  - state enum {S_LOAD, S_ISSUE, S_WAIT, S_STORE};
  - localparam BLK_W = 128;
  - function beats(bus_w).
- One sub-module: rc6_blk_fifo (parametrised BLK_W × DEPTH synchronous FIFO with count, full and empty; same reset rules).
- Beat assembly, beat slicing and the FSM stay in rc6_chip_io.

Test Plan:
- Bench setup for all scenarios: BUS_W = 32, DEPTH = 2, and a core stub that returns ~din three cycles after core_start.
- Basic path: drive beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - core_din = 0x0F0E0D0C_0B0A0908_07060504_03020100; core_start is high exactly one cycle after the 4th beat.
  - Output beats are 0xFCFDFEFF, 0xF8F9FAFB, 0xF4F5F6F7, 0xF0F1F2F3; blk_cnt = 1.
- Backpressure: hold outen = 0 and send 3 blocks.
  - fifo_full rises after block 2 and the FSM holds in S_STORE with in_ready = 0.
  - Drain 4 beats: block 3 is written the cycle after the pop; blk_cnt = 3.
- Mode latch: mode_in = 1 on beat 0 and 0 on beats 1–3 → core_mode = 1 throughout S_ISSUE and S_WAIT.
- Mid-operation clear: pulse zset after beat 2 of a block.
  - in_ready = 1, out_valid = 0, blk_cnt = 0.
  - A stray core_done afterwards produces no FIFO write.
- Async reset: assert reset between clock edges while out_valid = 1 → out_valid and data_out go to 0 before the next edge.
- Width sweep: BUS_W = 128, DEPTH = 1 → single-beat blocks; back-to-back blocks with outen held at 1 complete with one output beat per block and no lost data.
